// File: rtl/galaga_pkg.sv
// galaga_pkg: shared types and constants for the Galaga-style playfield.
// Holds the coordinate type, playfield bounds, ship start position and
// size, the player-missile defaults, and the launch-position helpers
// used by the missile controller.
package galaga_pkg;

   typedef logic [9:0] coord_t;

   // Playfield bounds (pixels)
   localparam coord_t PlayMinX = 10'd133;
   localparam coord_t PlayMaxX = 10'd506;
   localparam coord_t PlayMinY = 10'd0;
   localparam coord_t PlayMaxY = 10'd479;

   // Player ship start position and width
   localparam coord_t ShipInitX = 10'd304;
   localparam coord_t ShipInitY = 10'd400;
   localparam coord_t ShipSize  = 10'd16;

   // Player-missile defaults
   localparam int unsigned MslNumDef      = 32'd2;
   localparam int unsigned MslStepYDef    = 32'd4;
   localparam int unsigned MslMinYDef     = 32'd0;
   localparam int unsigned MslWidthDef    = 32'd2;
   localparam int unsigned MslHeightDef   = 32'd8;
   localparam int unsigned MslCooldownDef = 32'd8;

   // Missile left x centred on the ship nose; wraps in 10 bits, no clamp.
   function automatic coord_t launch_x(input coord_t ship_x, input coord_t ship_size,
                                       input int unsigned missile_w);
      launch_x = ship_x + (ship_size >> 1'b1) - coord_t'(missile_w >> 1'b1);
   endfunction

   // Missile top y just above the ship, clamped to the top playfield row.
   function automatic coord_t launch_y(input coord_t ship_y, input int unsigned min_y,
                                       input int unsigned missile_h);
      if (ship_y >= coord_t'(min_y + missile_h)) begin
         launch_y = ship_y - coord_t'(missile_h);
      end else begin
         launch_y = coord_t'(min_y);
      end
   endfunction

endpackage

// File: rtl/pc_missile_ctrl_if.sv
// pc_missile_ctrl_if: bus between the game logic and the player-missile
// controller.
//   fire_i, ship_xpos_i/ypos_i/size_i, hit_i       : towards the controller
//   missile_active_o, missile_xpos_o/ypos_o        : per-slot sprite state,
//                                                    slot k at [10k+9:10k]
//   fired_o (launch pulse), shots_o (launch count) : from the controller
// master = game side (drives fire/ship/hit), slave = controller.
interface pc_missile_ctrl_if
   import galaga_pkg::*;
#(
   parameter int unsigned NumMissiles = MslNumDef
);
   logic                        fire_i;
   coord_t                      ship_xpos_i;
   coord_t                      ship_ypos_i;
   coord_t                      ship_size_i;
   logic [NumMissiles-1:0]      hit_i;
   logic [NumMissiles-1:0]      missile_active_o;
   logic [10*NumMissiles-1:0]   missile_xpos_o;
   logic [10*NumMissiles-1:0]   missile_ypos_o;
   logic                        fired_o;
   logic [15:0]                 shots_o;

   modport master (
      output fire_i, ship_xpos_i, ship_ypos_i, ship_size_i, hit_i,
      input  missile_active_o, missile_xpos_o, missile_ypos_o, fired_o, shots_o
   );

   modport slave (
      input  fire_i, ship_xpos_i, ship_ypos_i, ship_size_i, hit_i,
      output missile_active_o, missile_xpos_o, missile_ypos_o, fired_o, shots_o
   );
endinterface

// File: rtl/missile_slot.sv
// missile_slot: one player-missile slot.
//   frame_clk_i, reset_i : frame tick, async active-high reset
//   launch_i             : load launch_x_i/launch_y_i and go live (slot idle)
//   hit_i                : collision kill, ignored while idle
//   active_o, xpos_o, ypos_o : registered slot state
// A live missile is killed by a hit, retired once it cannot step up
// without crossing the top row, and otherwise climbs StepY per frame.
module missile_slot
   import galaga_pkg::*;
#(
   parameter int unsigned StepY = MslStepYDef,
   parameter int unsigned MinY  = MslMinYDef
) (
   input  logic   frame_clk_i,
   input  logic   reset_i,
   input  logic   launch_i,
   input  coord_t launch_x_i,
   input  coord_t launch_y_i,
   input  logic   hit_i,
   output logic   active_o,
   output coord_t xpos_o,
   output coord_t ypos_o
);
   localparam coord_t TopLimit = coord_t'(MinY + StepY);
   localparam coord_t StepC    = coord_t'(StepY);

   logic   active_d, active_q;
   coord_t x_d, x_q;
   coord_t y_d, y_q;

   // Next slot state: launch when idle, else hit > off-top > climb.
   always_comb begin
      active_d = active_q;
      x_d      = x_q;
      y_d      = y_q;
      if (!active_q) begin
         if (launch_i) begin
            active_d = 1'b1;
            x_d      = launch_x_i;
            y_d      = launch_y_i;
         end else begin
            active_d = 1'b0;
         end
      end else if (hit_i || (y_q < TopLimit)) begin
         active_d = 1'b0;
         x_d      = '0;
         y_d      = '0;
      end else begin
         y_d = y_q - StepC;
      end
   end

   // Slot state register.
   always_ff @(posedge frame_clk_i or posedge reset_i) begin
      if (reset_i) begin
         active_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
      end else begin
         active_q <= active_d;
         x_q      <= x_d;
         y_q      <= y_d;
      end
   end

   assign active_o = active_q;
   assign xpos_o   = x_q;
   assign ypos_o   = y_q;
endmodule

// File: rtl/pc_missile_ctrl.sv
// pc_missile_ctrl: player-missile controller, clocked by the frame tick.
//   frame_clk_i, reset_i : frame tick, async active-high reset
//   bus (slave)          : fire/ship/hit in; missile sprites, fired_o, shots_o out
// Detects the fire-button rising edge, enforces the launcher cooldown,
// allocates the lowest idle slot, and counts launches. Slot motion and
// retirement live in missile_slot.
module pc_missile_ctrl
   import galaga_pkg::*;
#(
   parameter int unsigned NumMissiles    = MslNumDef,
   parameter int unsigned StepY          = MslStepYDef,
   parameter int unsigned MinY           = MslMinYDef,
   parameter int unsigned MissileW       = MslWidthDef,
   parameter int unsigned MissileH       = MslHeightDef,
   parameter int unsigned CooldownFrames = MslCooldownDef
) (
   input  logic              frame_clk_i,
   input  logic              reset_i,
   pc_missile_ctrl_if.slave  bus
);
   localparam int unsigned CdW = (CooldownFrames > 0) ? $clog2(CooldownFrames + 1) : 1;

   logic                   fire_d, fire_q;
   logic                   fired_d, fired_q;
   logic [15:0]            shots_d, shots_q;
   logic [CdW-1:0]         cooldown_d, cooldown_q;

   logic                   fire_rise_s;
   logic                   free_found_s;
   logic                   launch_go_s;
   logic [NumMissiles-1:0] launch_sel_s;
   logic [NumMissiles-1:0] launch_s;
   logic [NumMissiles-1:0] active_s;
   coord_t                 launch_x_s, launch_y_s;
   coord_t                 xpos_s [NumMissiles];
   coord_t                 ypos_s [NumMissiles];

   assign fire_rise_s = bus.fire_i & ~fire_q;
   assign launch_x_s  = launch_x(bus.ship_xpos_i, bus.ship_size_i, MissileW);
   assign launch_y_s  = launch_y(bus.ship_ypos_i, MinY, MissileH);

   // Lowest-index idle slot, judged on registered state so a slot retired
   // this frame only becomes available next frame.
   always_comb begin
      launch_sel_s = '0;
      free_found_s = 1'b0;
      for (int k = 0; k < NumMissiles; k++) begin
         if (!active_s[k] && !free_found_s) begin
            launch_sel_s[k] = 1'b1;
            free_found_s    = 1'b1;
         end else begin
            launch_sel_s[k] = 1'b0;
         end
      end
   end

   assign launch_go_s = fire_rise_s & (cooldown_q == '0) & free_found_s;
   assign launch_s    = launch_go_s ? launch_sel_s : '0;

   // Launcher next state: edge history, pulse, shot count, cooldown.
   always_comb begin
      fire_d     = bus.fire_i;
      fired_d    = launch_go_s;
      shots_d    = shots_q;
      cooldown_d = cooldown_q;
      if (launch_go_s) begin
         shots_d    = shots_q + 16'd1;
         cooldown_d = CdW'(CooldownFrames);
      end else if (cooldown_q != '0) begin
         cooldown_d = cooldown_q - CdW'(1'b1);
      end else begin
         cooldown_d = '0;
      end
   end

   // Launcher registers; fire_q resets high so a held button cannot fire.
   always_ff @(posedge frame_clk_i or posedge reset_i) begin
      if (reset_i) begin
         fire_q     <= 1'b1;
         fired_q    <= 1'b0;
         shots_q    <= '0;
         cooldown_q <= '0;
      end else begin
         fire_q     <= fire_d;
         fired_q    <= fired_d;
         shots_q    <= shots_d;
         cooldown_q <= cooldown_d;
      end
   end

   for (genvar k = 0; k < NumMissiles; k++) begin : g_slot
      missile_slot #(
         .StepY (StepY),
         .MinY  (MinY)
      ) u_slot (
         .frame_clk_i (frame_clk_i),
         .reset_i     (reset_i),
         .launch_i    (launch_s[k]),
         .launch_x_i  (launch_x_s),
         .launch_y_i  (launch_y_s),
         .hit_i       (bus.hit_i[k]),
         .active_o    (active_s[k]),
         .xpos_o      (xpos_s[k]),
         .ypos_o      (ypos_s[k])
      );
   end

   // Pack per-slot coordinates onto the sprite bus.
   always_comb begin
      bus.missile_xpos_o = '0;
      bus.missile_ypos_o = '0;
      for (int k = 0; k < NumMissiles; k++) begin
         bus.missile_xpos_o[10*k +: 10] = xpos_s[k];
         bus.missile_ypos_o[10*k +: 10] = ypos_s[k];
      end
   end

   assign bus.missile_active_o = active_s;
   assign bus.fired_o          = fired_q;
   assign bus.shots_o          = shots_q;
endmodule

// File: tb/tb_pc_missile_ctrl.sv
// Scoreboard bench for pc_missile_ctrl: each frame of directed stimulus
// pushes its hand-computed expected outputs; a monitor pops and compares
// one entry after every rising frame edge.
module tb_pc_missile_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;

   pc_missile_ctrl_if #(.NumMissiles(2)) bus ();

   pc_missile_ctrl dut (
      .frame_clk_i (clk),
      .reset_i     (rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  act;
      logic [9:0]  x0, y0, x1, y1;
      logic        fired;
      logic [15:0] shots;
      int          idx;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   fr    = 0;
   localparam int X = 311;

   // Drive one frame's inputs before its rising edge and queue the expected result.
   task automatic frame(input logic f, input int yp, input logic [1:0] h,
                        input logic [1:0] act, input int x0, input int y0,
                        input int x1, input int y1, input logic fd, input int sh);
      exp_t e;
      @(negedge clk);
      bus.fire_i      = f;
      bus.ship_ypos_i = 10'(yp);
      bus.hit_i       = h;
      fr++;
      e.act = act; e.x0 = 10'(x0); e.y0 = 10'(y0); e.x1 = 10'(x1); e.y1 = 10'(y1);
      e.fired = fd; e.shots = 16'(sh); e.idx = fr;
      exp_q.push_back(e);
   endtask

   // Immediate check that every output is at its reset value.
   task automatic check_zero(input string name);
      n_cmp++;
      if (bus.missile_active_o !== 2'b00 || bus.missile_xpos_o !== 20'd0 ||
          bus.missile_ypos_o !== 20'd0 || bus.fired_o !== 1'b0 || bus.shots_o !== 16'd0) begin
         n_bad++;
         $display("FAIL %s: act=%b x=%h y=%h fired=%b shots=%0d, required all zero",
                  name, bus.missile_active_o, bus.missile_xpos_o, bus.missile_ypos_o,
                  bus.fired_o, bus.shots_o);
      end
   endtask

   // Monitor: compare DUT outputs against the scoreboard after each frame edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.missile_active_o !== e.act ||
                bus.missile_xpos_o[9:0] !== e.x0 || bus.missile_ypos_o[9:0] !== e.y0 ||
                bus.missile_xpos_o[19:10] !== e.x1 || bus.missile_ypos_o[19:10] !== e.y1 ||
                bus.fired_o !== e.fired || bus.shots_o !== e.shots) begin
               n_bad++;
               $display("FAIL frame%0d: got act=%b s0=(%0d,%0d) s1=(%0d,%0d) fired=%b shots=%0d; required act=%b s0=(%0d,%0d) s1=(%0d,%0d) fired=%b shots=%0d",
                        e.idx, bus.missile_active_o, bus.missile_xpos_o[9:0],
                        bus.missile_ypos_o[9:0], bus.missile_xpos_o[19:10],
                        bus.missile_ypos_o[19:10], bus.fired_o, bus.shots_o,
                        e.act, e.x0, e.y0, e.x1, e.y1, e.fired, e.shots);
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      bus.fire_i      = 1'b1;
      bus.ship_xpos_i = 10'd304;
      bus.ship_ypos_i = 10'd400;
      bus.ship_size_i = 10'd16;
      bus.hit_i       = 2'b00;
      #1 rst = 1'b1;
      #1 check_zero("reset_values");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Button held through reset must not fire.
      frame(1'b1, 400, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0);          // F1
      frame(1'b0, 400, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0);          // F2
      frame(1'b1, 400, 2'b00, 2'b01, X, 392, 0, 0, 1'b1, 1);        // F3 launch s0
      for (int i = 1; i <= 20; i++)                                 // F4..F23 held
         frame(1'b1, 400, 2'b00, 2'b01, X, 392 - 4*i, 0, 0, 1'b0, 1);
      frame(1'b0, 400, 2'b00, 2'b01, X, 308, 0, 0, 1'b0, 1);        // F24
      frame(1'b1, 400, 2'b00, 2'b11, X, 304, X, 392, 1'b1, 2);      // F25 launch s1
      for (int i = 1; i <= 8; i++)                                  // F26..F33
         frame(1'b0, 400, 2'b00, 2'b11, X, 304 - 4*i, X, 392 - 4*i, 1'b0, 2);
      frame(1'b1, 400, 2'b00, 2'b11, X, 268, X, 356, 1'b0, 2);      // F34 no free slot
      frame(1'b0, 400, 2'b00, 2'b11, X, 264, X, 352, 1'b0, 2);      // F35
      frame(1'b1, 400, 2'b01, 2'b10, 0, 0, X, 348, 1'b0, 2);        // F36 hit s0 + rise
      frame(1'b0, 400, 2'b01, 2'b10, 0, 0, X, 344, 1'b0, 2);        // F37 hit on idle s0
      frame(1'b1, 400, 2'b01, 2'b11, X, 392, X, 340, 1'b1, 3);      // F38 launch s0 despite hit
      frame(1'b0, 400, 2'b10, 2'b01, X, 388, 0, 0, 1'b0, 3);        // F39 hit s1
      for (int i = 2; i <= 7; i++)                                  // F40..F45
         frame(1'b0, 400, 2'b00, 2'b01, X, 392 - 4*i, 0, 0, 1'b0, 3);
      frame(1'b1, 400, 2'b00, 2'b01, X, 360, 0, 0, 1'b0, 3);        // F46 rise at k+8 dropped
      frame(1'b0, 400, 2'b00, 2'b01, X, 356, 0, 0, 1'b0, 3);        // F47
      frame(1'b1, 400, 2'b00, 2'b11, X, 352, X, 392, 1'b1, 4);      // F48 launch s1
      frame(1'b0, 400, 2'b01, 2'b10, 0, 0, X, 388, 1'b0, 4);        // F49 hit s0
      for (int i = 2; i <= 8; i++)                                  // F50..F56
         frame(1'b0, 400, 2'b00, 2'b10, 0, 0, X, 392 - 4*i, 1'b0, 4);
      frame(1'b1, 14, 2'b00, 2'b11, X, 6, X, 356, 1'b1, 5);         // F57 rise at k+9 launches
      frame(1'b0, 14, 2'b00, 2'b11, X, 2, X, 352, 1'b0, 5);         // F58
      frame(1'b0, 14, 2'b00, 2'b10, 0, 0, X, 348, 1'b0, 5);         // F59 off top
      for (int i = 12; i <= 17; i++)                                // F60..F65
         frame(1'b0, 4, 2'b00, 2'b10, 0, 0, X, 392 - 4*i, 1'b0, 5);
      frame(1'b1, 4, 2'b00, 2'b11, X, 0, X, 320, 1'b1, 6);          // F66 clamped launch
      frame(1'b1, 4, 2'b00, 2'b10, 0, 0, X, 316, 1'b0, 6);          // F67 y=0 retires

      // Asynchronous reset mid-flight with fire held.
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      frame(1'b1, 400, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0);          // held: no launch
      frame(1'b1, 400, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0);
      frame(1'b0, 400, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 0);
      frame(1'b1, 400, 2'b00, 2'b01, X, 392, 0, 0, 1'b1, 1);        // fresh rise launches
      frame(1'b0, 400, 2'b00, 2'b01, X, 388, 0, 0, 1'b0, 1);

      // Let the monitor drain the scoreboard, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
